// File: rtl/fft_twiddle_bfly_ctrl_if.sv
// Handshake bundle between the butterfly controller, the stage memory reader/writer
// and the twiddle multiplier (en/outValid protocol).
interface fft_twiddle_bfly_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a_i;
  logic [15:0] in_a_q;
  logic [15:0] in_b_i;
  logic [15:0] in_b_q;
  logic [15:0] in_k;
  logic        mul_en;
  logic [15:0] mul_data_i;
  logic [15:0] mul_data_q;
  logic [15:0] mul_fi_deg;
  logic        mul_valid;
  logic [15:0] mul_out_i;
  logic [15:0] mul_out_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x0_i;
  logic [15:0] out_x0_q;
  logic [15:0] out_x1_i;
  logic [15:0] out_x1_q;
  logic        err;

  // controller side
  modport master (
    input  in_valid, in_a_i, in_a_q, in_b_i, in_b_q, in_k,
    output in_ready,
    output mul_en, mul_data_i, mul_data_q, mul_fi_deg,
    input  mul_valid, mul_out_i, mul_out_q,
    output out_valid, out_x0_i, out_x0_q, out_x1_i, out_x1_q,
    input  out_ready,
    output err
  );

  // environment side: reader, writer and multiplier
  modport slave (
    output in_valid, in_a_i, in_a_q, in_b_i, in_b_q, in_k,
    input  in_ready,
    input  mul_en, mul_data_i, mul_data_q, mul_fi_deg,
    output mul_valid, mul_out_i, mul_out_q,
    input  out_valid, out_x0_i, out_x0_q, out_x1_i, out_x1_q,
    output out_ready,
    input  err
  );
endinterface

// File: rtl/fft_twiddle_bfly_ctrl.sv
// Radix-2 butterfly controller: issues b/k to the twiddle multiplier, waits for w,
// emits a+w / a-w with shift or saturation. Optional watchdog: FFT_BFLY_WDOG_EN.
module fft_twiddle_bfly_ctrl #(
  parameter int SCALE   = 1,
  parameter int TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     rst,
  fft_twiddle_bfly_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    OUT       = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t      state_r;
  logic        in_ready_r;
  logic        issue_r;
  logic        out_valid_r;
  logic        err_r;
  logic [15:0] a_i_r;
  logic [15:0] a_q_r;
  logic [15:0] b_i_r;
  logic [15:0] b_q_r;
  logic [15:0] k_r;
  logic [15:0] x0_i_r;
  logic [15:0] x0_q_r;
  logic [15:0] x1_i_r;
  logic [15:0] x1_q_r;
  logic        capture_s;

`ifdef FFT_BFLY_WDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt_r;
`endif

  function automatic logic [15:0] sat16(input logic [16:0] s);
    if (s[16] != s[15]) begin
      return s[16] ? 16'h8000 : 16'h7fff;
    end else begin
      return s[15:0];
    end
  endfunction

  // One lane of the butterfly with 17-bit headroom before scaling.
  function automatic logic [15:0] bfly_lane(input logic [15:0] a, input logic [15:0] w,
                                            input logic sub);
    logic [16:0] s;
    if (sub) begin
      s = {a[15], a} - {w[15], w};
    end else begin
      s = {a[15], a} + {w[15], w};
    end
    if (SCALE != 0) begin
      return s[16:1];
    end else begin
      return sat16(s);
    end
  endfunction

  // A high outValid in either wait state means the multiplier result is ready.
  assign capture_s = ((state_r == WAIT_LOW) || (state_r == WAIT_HIGH)) && bus.mul_valid;

  // mul_en is gated by the live outValid so a request never lands on a busy multiplier.
  assign bus.mul_en     = issue_r & bus.mul_valid;
  assign bus.in_ready   = in_ready_r;
  assign bus.mul_data_i = b_i_r;
  assign bus.mul_data_q = b_q_r;
  assign bus.mul_fi_deg = k_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_x0_i   = x0_i_r;
  assign bus.out_x0_q   = x0_q_r;
  assign bus.out_x1_i   = x1_i_r;
  assign bus.out_x1_q   = x1_q_r;
  assign bus.err        = err_r;

  // Transaction FSM with its registered handshake and data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      issue_r     <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      a_i_r       <= 16'd0;
      a_q_r       <= 16'd0;
      b_i_r       <= 16'd0;
      b_q_r       <= 16'd0;
      k_r         <= 16'd0;
      x0_i_r      <= 16'd0;
      x0_q_r      <= 16'd0;
      x1_i_r      <= 16'd0;
      x1_q_r      <= 16'd0;
`ifdef FFT_BFLY_WDOG_EN
      wd_cnt_r    <= 16'd0;
`endif
    end else begin
`ifdef FFT_BFLY_WDOG_EN
      wd_cnt_r <= ((state_r == WAIT_LOW) || (state_r == WAIT_HIGH)) ? wd_cnt_r + 16'd1 : 16'd0;
`endif
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_i_r      <= bus.in_a_i;
            a_q_r      <= bus.in_a_q;
            b_i_r      <= bus.in_b_i;
            b_q_r      <= bus.in_b_q;
            k_r        <= bus.in_k;
            in_ready_r <= 1'b0;
            issue_r    <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mul_valid) begin
            issue_r <= 1'b0;
            state_r <= WAIT_LOW;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (capture_s) begin
            x0_i_r      <= bfly_lane(a_i_r, bus.mul_out_i, 1'b0);
            x0_q_r      <= bfly_lane(a_q_r, bus.mul_out_q, 1'b0);
            x1_i_r      <= bfly_lane(a_i_r, bus.mul_out_i, 1'b1);
            x1_q_r      <= bfly_lane(a_q_r, bus.mul_out_q, 1'b1);
            out_valid_r <= 1'b1;
            state_r     <= OUT;
`ifdef FFT_BFLY_WDOG_EN
          end else if (wd_cnt_r == WD_LAST) begin
            err_r   <= 1'b1;
            state_r <= ERR;
`endif
          end else if (state_r == WAIT_LOW) begin
            state_r <= WAIT_HIGH;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        ERR: begin
          // Locked until rst; keep the handshakes quiet.
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          issue_r     <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          issue_r     <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_twiddle_bfly_ctrl.sv
// Directed bench for fft_twiddle_bfly_ctrl: one DUT per SCALE setting driven in
// lockstep, with a small multiplier model (4-point busy, pass-through, stuck-low).
module tb_fft_twiddle_bfly_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        in_valid = 1'b0;
  logic [15:0] in_a_i = 16'd0, in_a_q = 16'd0, in_b_i = 16'd0, in_b_q = 16'd0, in_k = 16'd0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'd0;      // 0: 4-point busy model, 1: pass-through, 2: stuck low
  logic [15:0] w_i = 16'd0, w_q = 16'd0;
  logic        sel_sat = 1'b0;   // 0 observes SCALE=1 DUT, 1 observes SCALE=0 DUT
  logic [1:0]  busy = 2'd0;

  logic        m_valid;
  logic [15:0] m_out_i, m_out_q;
  logic        o_in_ready, o_mul_en, o_out_valid, o_err;
  logic [15:0] o_mul_data_i, o_mul_data_q, o_mul_fi_deg, o_x0_i, o_x0_q, o_x1_i, o_x1_q;

  fft_twiddle_bfly_ctrl_if bus1 ();
  fft_twiddle_bfly_ctrl_if bus0 ();

  fft_twiddle_bfly_ctrl #(.SCALE(1), .TIMEOUT(8)) u_s1 (.clk(clk), .rst(rst), .bus(bus1.master));
  fft_twiddle_bfly_ctrl #(.SCALE(0), .TIMEOUT(8)) u_s0 (.clk(clk), .rst(rst), .bus(bus0.master));

  assign bus1.in_valid = in_valid;   assign bus0.in_valid = in_valid;
  assign bus1.in_a_i = in_a_i;       assign bus0.in_a_i = in_a_i;
  assign bus1.in_a_q = in_a_q;       assign bus0.in_a_q = in_a_q;
  assign bus1.in_b_i = in_b_i;       assign bus0.in_b_i = in_b_i;
  assign bus1.in_b_q = in_b_q;       assign bus0.in_b_q = in_b_q;
  assign bus1.in_k = in_k;           assign bus0.in_k = in_k;
  assign bus1.out_ready = out_ready; assign bus0.out_ready = out_ready;
  assign bus1.mul_valid = m_valid;   assign bus0.mul_valid = m_valid;
  assign bus1.mul_out_i = m_out_i;   assign bus0.mul_out_i = m_out_i;
  assign bus1.mul_out_q = m_out_q;   assign bus0.mul_out_q = m_out_q;

  assign o_in_ready   = sel_sat ? bus0.in_ready   : bus1.in_ready;
  assign o_mul_en     = sel_sat ? bus0.mul_en     : bus1.mul_en;
  assign o_mul_data_i = sel_sat ? bus0.mul_data_i : bus1.mul_data_i;
  assign o_mul_data_q = sel_sat ? bus0.mul_data_q : bus1.mul_data_q;
  assign o_mul_fi_deg = sel_sat ? bus0.mul_fi_deg : bus1.mul_fi_deg;
  assign o_out_valid  = sel_sat ? bus0.out_valid  : bus1.out_valid;
  assign o_x0_i       = sel_sat ? bus0.out_x0_i   : bus1.out_x0_i;
  assign o_x0_q       = sel_sat ? bus0.out_x0_q   : bus1.out_x0_q;
  assign o_x1_i       = sel_sat ? bus0.out_x1_i   : bus1.out_x1_i;
  assign o_x1_q       = sel_sat ? bus0.out_x1_q   : bus1.out_x1_q;
  assign o_err        = sel_sat ? bus0.err        : bus1.err;

  // Multiplier model: after a request outValid drops for two cycles.
  always @(posedge clk) begin
    if (o_mul_en === 1'b1) busy <= 2'd2;
    else if (busy != 2'd0) busy <= busy - 2'd1;
  end
  assign m_valid = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (busy == 2'd0);
  assign m_out_i = (mode == 2'd1) ? o_mul_data_i : w_i;
  assign m_out_q = (mode == 2'd1) ? o_mul_data_q : w_q;

  // Stimulus helper: present one request, then wait (bounded) for out_valid.
  task automatic do_txn(input logic [15:0] ai, input logic [15:0] aq, input logic [15:0] bi,
                        input logic [15:0] bq, input logic [15:0] k,
                        output int lat, output int en_cnt, output logic rdy1);
    @(negedge clk);
    in_a_i = ai; in_a_q = aq; in_b_i = bi; in_b_q = bq; in_k = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; en_cnt = 0; rdy1 = o_in_ready;
    for (int i = 1; i <= 40; i++) begin
      if (o_mul_en === 1'b1) en_cnt++;
      if (o_out_valid === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", o_out_valid); end
    checks++; if (o_mul_en !== 1'b0) begin errors++; $display("FAIL reset_mul_en got=%b want=0", o_mul_en); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", o_err); end
    checks++; if ({o_x0_i, o_x1_q, o_mul_data_i, o_mul_fi_deg} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", {o_x0_i, o_x1_q, o_mul_data_i, o_mul_fi_deg}); end
    rst = 1'b0;
  endtask

  task automatic test_scale1_basic();
    int lat, en; logic rdy1;
    sel_sat = 1'b0; mode = 2'd0; w_i = 16'd300; w_q = -16'sd100;
    do_txn(16'd1000, 16'd2000, 16'd7, 16'd8, 16'd3, lat, en, rdy1);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", lat); end
    checks++; if (en !== 1) begin errors++; $display("FAIL basic_mul_en_pulses got=%0d want=1", en); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy got=%b want=0", rdy1); end
    checks++; if (o_x0_i !== 16'd650 || o_x0_q !== 16'd950) begin errors++; $display("FAIL basic_x0 got=(%0d,%0d) want=(650,950)", $signed(o_x0_i), $signed(o_x0_q)); end
    checks++; if (o_x1_i !== 16'd350 || o_x1_q !== 16'd1050) begin errors++; $display("FAIL basic_x1 got=(%0d,%0d) want=(350,1050)", $signed(o_x1_i), $signed(o_x1_q)); end
    checks++; if (o_mul_data_i !== 16'd7 || o_mul_data_q !== 16'd8 || o_mul_fi_deg !== 16'd3) begin errors++; $display("FAIL basic_mul_args got=(%0d,%0d,%0d) want=(7,8,3)", o_mul_data_i, o_mul_data_q, o_mul_fi_deg); end
    release_out();
    checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got valid=%b ready=%b want 0/1", o_out_valid, o_in_ready); end
  endtask

  task automatic test_saturate();
    int lat, en; logic rdy1;
    sel_sat = 1'b1; mode = 2'd0; w_i = 16'd5000; w_q = -16'sd5000;
    do_txn(16'd30000, -16'sd30000, 16'd1, 16'd1, 16'd0, lat, en, rdy1);
    checks++; if (o_x0_i !== 16'h7fff || o_x0_q !== 16'h8000) begin errors++; $display("FAIL sat_x0 got=(%0d,%0d) want=(32767,-32768)", $signed(o_x0_i), $signed(o_x0_q)); end
    checks++; if (o_x1_i !== 16'd25000 || o_x1_q !== -16'sd25000) begin errors++; $display("FAIL sat_x1 got=(%0d,%0d) want=(25000,-25000)", $signed(o_x1_i), $signed(o_x1_q)); end
    release_out();
  endtask

  task automatic test_arith_shift();
    int lat, en; logic rdy1;
    sel_sat = 1'b0; mode = 2'd0; w_i = 16'd0; w_q = 16'd0;
    do_txn(-16'sd3, 16'd0, 16'd0, 16'd0, 16'd0, lat, en, rdy1);
    checks++; if (o_x0_i !== -16'sd2 || o_x0_q !== 16'd0) begin errors++; $display("FAIL shift_x0 got=(%0d,%0d) want=(-2,0)", $signed(o_x0_i), $signed(o_x0_q)); end
    checks++; if (o_x1_i !== -16'sd2 || o_x1_q !== 16'd0) begin errors++; $display("FAIL shift_x1 got=(%0d,%0d) want=(-2,0)", $signed(o_x1_i), $signed(o_x1_q)); end
    release_out();
  endtask

  task automatic test_pass_through();
    int lat, en; logic rdy1;
    sel_sat = 1'b1; mode = 2'd1;
    do_txn(16'd0, 16'd0, 16'd10, 16'd20, 16'd5, lat, en, rdy1);
    checks++; if (lat !== 3) begin errors++; $display("FAIL pass_latency got=%0d want=3", lat); end
    checks++; if (en !== 1) begin errors++; $display("FAIL pass_mul_en_pulses got=%0d want=1", en); end
    checks++; if (o_x0_i !== 16'd10 || o_x0_q !== 16'd20) begin errors++; $display("FAIL pass_x0 got=(%0d,%0d) want=(10,20)", $signed(o_x0_i), $signed(o_x0_q)); end
    checks++; if (o_x1_i !== -16'sd10 || o_x1_q !== -16'sd20) begin errors++; $display("FAIL pass_x1 got=(%0d,%0d) want=(-10,-20)", $signed(o_x1_i), $signed(o_x1_q)); end
    release_out();
    mode = 2'd0;
  endtask

  task automatic test_back_to_back_stall();
    int lat, en; logic rdy1;
    sel_sat = 1'b0; mode = 2'd0; w_i = 16'd100; w_q = 16'd200;
    do_txn(16'd400, 16'd600, 16'd2, 16'd2, 16'd1, lat, en, rdy1);
    in_a_i = 16'd9999; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (o_out_valid !== 1'b1 || o_x0_i !== 16'd250 || o_x0_q !== 16'd400 || o_x1_i !== 16'd150 || o_x1_q !== 16'd200) begin errors++; $display("FAIL stall_hold c=%0d got valid=%b x=(%0d,%0d,%0d,%0d) want 1 (250,400,150,200)", c, o_out_valid, o_x0_i, o_x0_q, o_x1_i, o_x1_q); end
      checks++; if (o_in_ready !== 1'b0 || o_mul_en !== 1'b0) begin errors++; $display("FAIL stall_quiet c=%0d got ready=%b en=%b want 0/0", c, o_in_ready, o_mul_en); end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got valid=%b ready=%b want 0/1", o_out_valid, o_in_ready); end
    @(negedge clk);
    checks++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_mul_en !== 1'b0) begin errors++; $display("FAIL stall_idle got valid=%b ready=%b en=%b want 0/1/0", o_out_valid, o_in_ready, o_mul_en); end
  endtask

  task automatic test_reset_mid();
    int en; bit seen;
    sel_sat = 1'b0; mode = 2'd0; w_i = 16'd4; w_q = 16'd6;
    @(negedge clk);
    in_a_i = 16'd0; in_a_q = 16'd0; in_b_i = 16'd3; in_b_q = 16'd3; in_k = 16'd9; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_waiting got ready=%b valid=%b want 0/0", o_in_ready, o_out_valid); end
    mode = 2'd2; rst = 1'b1;
    @(negedge clk);
    checks++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_mul_en !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got ready=%b valid=%b en=%b want 1/0/0", o_in_ready, o_out_valid, o_mul_en); end
    checks++; if ({o_x0_i, o_x0_q, o_x1_i, o_mul_data_i, o_mul_fi_deg} !== 80'd0) begin errors++; $display("FAIL rstmid_data got=%h want=0", {o_x0_i, o_x0_q, o_x1_i, o_mul_data_i, o_mul_fi_deg}); end
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_mul_en !== 1'b0 || o_in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_issue_hold c=%0d got en=%b ready=%b want 0/0", c, o_mul_en, o_in_ready); end
      @(negedge clk);
    end
    mode = 2'd0;
    #1;
    checks++; if (o_mul_en !== 1'b1) begin errors++; $display("FAIL rstmid_issue_go got en=%b want 1", o_mul_en); end
    en = 0; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_mul_en === 1'b1) en++;
      if (o_out_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen || en !== 1 || o_x0_i !== 16'd2 || o_x0_q !== 16'd3) begin errors++; $display("FAIL rstmid_result got seen=%b en=%0d x0=(%0d,%0d) want 1 1 (2,3)", seen, en, o_x0_i, o_x0_q); end
    release_out();
  endtask

  task automatic test_watchdog();
    sel_sat = 1'b0; mode = 2'd0; w_i = 16'd0; w_q = 16'd0;
    @(negedge clk);
    in_a_i = 16'd8; in_a_q = -16'sd8; in_b_i = 16'd1; in_b_q = 16'd1; in_k = 16'd0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (o_mul_en !== 1'b1) begin errors++; $display("FAIL wdog_issue got en=%b want 1", o_mul_en); end
    @(negedge clk); mode = 2'd2;
    repeat (7) @(negedge clk);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL wdog_before_limit got err=%b want 0", o_err); end
    @(negedge clk);
`ifdef FFT_BFLY_WDOG_EN
    checks++; if (o_err !== 1'b1 || o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL wdog_trip got err=%b ready=%b valid=%b want 1/0/0", o_err, o_in_ready, o_out_valid); end
    mode = 2'd0;
    repeat (20) @(negedge clk);
    checks++; if (o_err !== 1'b1 || o_in_ready !== 1'b0 || o_mul_en !== 1'b0) begin errors++; $display("FAIL wdog_sticky got err=%b ready=%b en=%b want 1/0/0", o_err, o_in_ready, o_mul_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (o_err !== 1'b0 || o_in_ready !== 1'b1) begin errors++; $display("FAIL wdog_clear got err=%b ready=%b want 0/1", o_err, o_in_ready); end
`else
    repeat (20) @(negedge clk);
    checks++; if (o_err !== 1'b0 || o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL nowdog_wait got err=%b ready=%b valid=%b want 0/0/0", o_err, o_in_ready, o_out_valid); end
    mode = 2'd0;
    @(negedge clk);
    checks++; if (o_out_valid !== 1'b1 || o_x0_i !== 16'd4 || o_x0_q !== 16'hfffc) begin errors++; $display("FAIL nowdog_late_result got valid=%b x0=(%0d,%0d) want 1 (4,-4)", o_out_valid, $signed(o_x0_i), $signed(o_x0_q)); end
    release_out();
    checks++; if (o_in_ready !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL nowdog_idle got ready=%b err=%b want 1/0", o_in_ready, o_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_scale1_basic();
    test_saturate();
    test_arith_shift();
    test_pass_through();
    test_back_to_back_stall();
    test_reset_mid();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_bfly_ctrl.md
# fft_twiddle_bfly_ctrl

Radix-2 butterfly controller that initiates the twiddle-multiplier handshake in one FFT stage. It accepts an operand pair (a, b) and a twiddle index, issues b and the index to the twiddle multiplier, waits for the multiplier's result w = b·W^k, and emits the butterfly outputs x0 = a + w and x1 = a − w with per-stage scaling or saturation. It sits between the stage's data memory reader and its writer, on the requesting side of the multiplier's en/outValid protocol.

## Interface
Parameters:
- SCALE, 1: 1 = arithmetic shift right by 1 on both outputs (truncate); 0 = no shift, saturate to 16 bits
- TIMEOUT, 64: watchdog limit in cycles (used only with FFT_BFLY_WDOG_EN)

Ports:
- clk  in  1  clock; one clock domain, everything on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept; high only in IDLE
- in_a_i, in_a_q  in  16  operand a, signed
- in_b_i, in_b_q  in  16  operand b, signed
- in_k  in  16  twiddle index, passed unchanged to multiplier
- mul_en  out  1  one-cycle request to multiplier
- mul_data_i, mul_data_q  out  16  b to multiplier
- mul_fi_deg  out  16  twiddle index to multiplier
- mul_valid  in  1  multiplier outValid (high = idle/result held)
- mul_out_i, mul_out_q  in  16  multiplier result w, signed
- out_valid  out  1  butterfly result present
- out_ready  in  1  downstream accepts
- out_x0_i, out_x0_q, out_x1_i, out_x1_q  out  16  butterfly results, signed
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, OUT, ERR.
- IDLE: in_ready=1. On in_valid: register a, b, k; go ISSUE.
- ISSUE: if mul_valid=1, drive mul_en=1 for exactly this cycle and go WAIT_LOW; else hold (multiplier still busy, e.g. after reset).
- WAIT_LOW: mul_valid=0 → WAIT_HIGH. mul_valid=1 → pass-through multiplier; capture mul_out this cycle and go OUT.
- WAIT_HIGH: mul_valid=1 → capture mul_out, go OUT.
- OUT: out_valid=1, outputs stable until out_ready=1; then IDLE.
- mul_data and mul_fi_deg hold the registered b and k from ISSUE until the state leaves WAIT_HIGH. They are not changed while the multiplier is busy.
- Arithmetic: 17-bit signed sums s0=a+w, s1=a−w per I/Q. SCALE=1 → out=s[16:1]. SCALE=0 → clamp to [−32768, 32767].
- Reset: all state to IDLE. mul_en=0, out_valid=0, err=0, in_ready=1, and all data outputs 0. A reset mid-transaction drops the transaction. The multiplier has no reset, so ISSUE waits for mul_valid=1 before the next request.

## Timing
- Accept at cycle T. mul_en at T+1 if mul_valid=1 at T+1.
- Capture at the first cycle with mul_valid=1 after the mul_valid=0 cycle, or at T+2 for pass-through. out_valid rises the cycle after capture.
- Latency from accept to out_valid equals the multiplier's busy time plus 3 cycles. For the 4-point multiplier (mul_valid low 2 cycles) this is 5 cycles.
- mul_en is never high on two consecutive cycles and never high when mul_valid=0.
- in_ready=0 from T+1 until the cycle after the out_valid/out_ready handshake. There is no overlap between transactions.
- in_valid and out_ready may change freely. in_valid while in_ready=0 is ignored.

## Configuration
- FFT_BFLY_WDOG_EN defined:
  - A counter runs in WAIT_LOW and WAIT_HIGH.
  - If it reaches TIMEOUT cycles without capture, the block goes to ERR and sets err=1.
  - In ERR, in_ready=0 and out_valid=0. Only rst clears ERR.
- FFT_BFLY_WDOG_EN undefined:
  - No counter; err is tied 0.
  - The block waits indefinitely in WAIT_LOW/WAIT_HIGH.
  - TIMEOUT is ignored.

## Test plan
- SCALE=1, a=(1000,2000), model returns w=(300,−100) → x0=(650,950), x1=(350,1050). mul_en is a single pulse. Latency is 5 cycles with the 4-point model.
- SCALE=0, a=(30000,−30000), w=(5000,−5000) → x0=(32767,−32768) saturated, x1=(25000,−25000).
- SCALE=1, a=(−3,0), w=(0,0) → x0=x1=(−2,0) (arithmetic shift).
- Pass-through multiplier (mul_valid held 1, mul_out=b), b=(10,20), a=(0,0), SCALE=0 → capture at T+2, x0=(10,20), x1=(−10,−20).
- out_ready held 0 for 10 cycles → outputs stable, in_ready=0, no further mul_en. Release → exactly one handshake, then IDLE.
- rst asserted in WAIT_HIGH with mul_valid held 0 → next cycle all outputs 0, IDLE. A new request stays in ISSUE until mul_valid=1.
- With FFT_BFLY_WDOG_EN and TIMEOUT=8, mul_valid stuck 0 → err=1 after 8 cycles, in_ready=0. err stays 1 until rst.
